gf2m_digit_serial_mult: RTL
===========================

// Module: gf2m_digit_serial_mult
// PURPOSE
//  Sequential GF(2^M) field multiplier: c = a*b mod P(x), polynomial basis.
//  Successor to the combinational full-width Karatsuba product: adds in-block
//  modular reduction, a digit width D so area can be traded against latency,
//  and a valid/ready handshake. Sits under the ECC point-arithmetic controller.
// PARAMETERS
//  M     163         field degree; operand and result width
//  D     8           digit width, b bits consumed per cycle; 1 <= D <= M
//  POLY  'hC9        low M bits of P(x), x^M implied (default x^163+x^7+x^6+x^3+1)
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  rst        in   1  synchronous reset, active-high
//  in_valid   in   1  a/b operands valid
//  in_ready   out  1  block can accept operands
//  a          in   M  multiplicand (must be < x^M)
//  b          in   M  multiplier (must be < x^M)
//  out_valid  out  1  c holds a finished result
//  out_ready  in   1  consumer takes c
//  c          out  M  a*b mod P(x)
//  op_count   out  32 completed multiplies (only with GF_MULT_OPCNT_EN)
// BEHAVIOUR
//  - NDIG = ceil(M/D); b zero-extended to NDIG*D bits, processed MSB digit first.
//  - Reset: state IDLE, in_ready=1, out_valid=0, c=0, acc=0, digit counter=0.
//  - FSM states IDLE / RUN / DONE:
//    IDLE: in_ready=1. On in_valid: latch a, b; acc<=0; cnt<=0; go RUN.
//    RUN : in_ready=0. Each cycle acc <= red(acc*x^D) ^ red(a*b_digit[cnt]);
//          cnt++; after the NDIG-th update go DONE with c<=final acc.
//    DONE: out_valid=1, c stable. On out_ready: out_valid<=0, go IDLE.
//  - red(): full reduction mod P within the same cycle (bitwise shift-and-fold);
//    acc and c are always < x^M.
//  - Latency: handshake accepted at edge k -> out_valid high after edge k+NDIG
//    (21 cycles for M=163, D=8). Throughput 1 op per NDIG+2 cycles minimum.
//  - in_ready only in IDLE; no operand accepted in RUN or DONE (no overlap).
//  - out_valid held with out_ready low: c, state unchanged indefinitely.
//  - in_valid and out_ready both high in DONE: result retired, return to IDLE;
//    new operands accepted no earlier than the next cycle.
//  - rst mid-RUN or in DONE: result discarded, all outputs to reset values.
//  - Operand ports sampled only on the accepting edge; later changes ignored.
//  - Field arithmetic is carry-less (XOR); no integer carries anywhere.
// CONFIGURATION
//  GF_MULT_OPCNT_EN defined: op_count port present; reset to 0, +1 on each
//    out_valid&out_ready retirement, wraps 2^32-1 -> 0; unaffected by stalls.
//  Not defined: op_count port and counter absent; all other behaviour identical.
// TESTING
//  - a=1, b=1 -> c=1, out_valid exactly NDIG cycles after accept (21 @ D=8).
//  - a=3, b=3 -> c=5 (carry-less, no reduction); a=0, b=any -> c=0.
//  - a=1<<162, b=2 -> c='hC9 (x^163 folded by P); a=1<<81, b=1<<81 -> c=1<<162.
//  - Hold out_ready=0 for 5 cycles in DONE -> c, out_valid stable; in_ready=0;
//    in_valid pulses during that time ignored.
//  - rst asserted at RUN cycle 10 -> next edge out_valid=0, c=0, in_ready=1;
//    fresh a=3,b=3 then completes with c=5.
//  - Random sweep vs. software GF(2^163) model at D in {1,8,163}; with
//    GF_MULT_OPCNT_EN, op_count equals number of retired results.

Source files
------------

// File: rtl/gf2m_digit_serial_mult_if.sv
// gf2m_digit_serial_mult_if: operand/result valid-ready channel of the GF(2^M) multiplier
interface gf2m_digit_serial_mult_if #(
    parameter int M = 163
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] c;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/gf2m_digit_serial_mult.sv
// gf2m_digit_serial_mult: digit-serial GF(2^M) multiplier, MSB digit first, optional op counter under GF_MULT_OPCNT_EN
module gf2m_digit_serial_mult #(
    parameter int           M    = 163,
    parameter int           D    = 8,
    parameter logic [M-1:0] POLY = 'hC9
) (
    input  logic        clk,
    input  logic        rst,
`ifdef GF_MULT_OPCNT_EN
    output logic [31:0] op_count,
`endif
    gf2m_digit_serial_mult_if.slave ifc
);
    localparam int NDIG = (M + D - 1) / D;
    localparam int W    = NDIG * D;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [M-1:0]  c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  step;
    logic          last;

    // multiply by x and fold x^M back through P(x)
    function automatic logic [M-1:0] xtime(input logic [M-1:0] t);
        return {t[M-2:0], 1'b0} ^ (t[M-1] ? POLY : '0);
    endfunction

    // one digit of Horner: acc*x^D + a*digit, reduced after every bit
    always_comb begin
        step = acc_q;
        for (int i = D - 1; i >= 0; i--)
            step = xtime(step) ^ (b_q[W-D+i] ? a_q : '0);
    end

    // next-state and datapath update for IDLE / RUN / DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        last    = cnt_q == CW'(NDIG - 1);
        case (state_q)
            IDLE: if (ifc.in_valid) begin
                a_d     = ifc.a;
                b_d     = W'(ifc.b);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                acc_d = step;
                b_d   = b_q << D;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    c_d     = step;
                    state_d = DONE;
                end
            end
            DONE: if (ifc.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ifc.in_ready  = state_q == IDLE;
    assign ifc.out_valid = state_q == DONE;
    assign ifc.c         = c_q;

`ifdef GF_MULT_OPCNT_EN
    logic [31:0] op_count_q, op_count_d;

    // count retirements, wrapping naturally at 2^32
    always_comb op_count_d = op_count_q + 32'(ifc.out_valid & ifc.out_ready);

    // retirement counter register
    always_ff @(posedge clk) begin
        if (rst) op_count_q <= '0;
        else     op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif
endmodule
